// File: rtl/hex_print_pkg.sv
`default_nettype none
// ============================================================================
// Module : hex_print_pkg
// Purpose: Shared types, ASCII constants and the round-robin winner search
//          used by the hex print arbiter.
// Revision: 1.0  initial release
// ============================================================================
package hex_print_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2,
    SEP  = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;
  localparam logic [7:0] ASCII_SPACE   = 8'h20;

  // First set request at or after ptr, wrapping at nreq-1 -> 0.
  // Requests are zero-padded to 8 lanes; ptr is always below nreq.
  function automatic logic [2:0] rr_winner(input logic [7:0]  req,
                                           input logic [2:0]  ptr,
                                           input int unsigned nreq);
    logic [2:0]  win;
    logic        found;
    int unsigned idx;
    win   = 3'd0;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = (32'(ptr) + i) % nreq;
      if (!found && (i < nreq) && req[idx[2:0]]) begin
        win   = idx[2:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex_nibble_to_ascii.sv
`default_nettype none
// ============================================================================
// Module : hex_nibble_to_ascii
// Purpose: Combinational 4-bit nibble to ASCII hex character.
// Ports  : i_nib  [3:0]  nibble value
//          o_char [7:0]  ASCII '0'-'9', then 'A'-'F' (UPPER=1) or 'a'-'f'
// Revision: 1.0  initial release
// ============================================================================
module hex_nibble_to_ascii
  import hex_print_pkg::*;
#(
  parameter bit UPPER = 1'b1
) (
  input  logic [3:0] i_nib,
  output logic [7:0] o_char
);

  logic [7:0] w_letter_base;

  assign w_letter_base = UPPER ? ASCII_UPPER_A : ASCII_LOWER_A;

  always_comb begin
    if (i_nib < 4'd10) begin
      o_char = ASCII_ZERO + {4'h0, i_nib};
    end else begin
      o_char = w_letter_base + {4'h0, i_nib} - 8'd10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hex_print_arbiter.sv
`default_nettype none
// ============================================================================
// Module : hex_print_arbiter
// Purpose: Round-robin arbiter sharing one byte-to-hex-ASCII path among NREQ
//          requesters. Each granted byte leaves as two ASCII characters, high
//          nibble first, on a valid/ready byte stream.
// Config : HEX_PRINT_SEPARATOR_EN - when defined, a space (0x20) follows each
//          byte's two characters.
// Ports  : clk, rst_n          clock, asynchronous active-low reset
//          i_req[NREQ]         per-requester print request, held until ack
//          i_req_data[8*NREQ]  byte of requester i at [8*i+7:8*i]
//          o_ack[NREQ]         one-cycle one-hot capture pulse
//          o_tx_valid/i_tx_ready/o_tx_byte  character stream
//          o_busy              FSM not in IDLE
// Revision: 1.0  initial release
// ============================================================================
module hex_print_arbiter
  import hex_print_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter bit          UPPER = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   i_req,
  input  logic [8*NREQ-1:0] i_req_data,
  output logic [NREQ-1:0]   o_ack,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic [7:0]        o_tx_byte,
  output logic              o_busy
);

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_ptr, w_ptr_nxt;
  // The high nibble is emitted on the grant edge, so only the low nibble
  // of the captured byte has to be held.
  logic [3:0]      r_lo_nib, w_lo_nib_nxt;
  logic [NREQ-1:0] r_ack, w_ack_nxt;
  logic            r_tx_valid, w_valid_nxt;
  logic [7:0]      r_tx_byte, w_byte_nxt;

  logic [7:0]      w_req8;
  logic [2:0]      w_win;
  logic [7:0]      w_win_byte;
  logic [2:0]      w_win_inc;
  logic [3:0]      w_nib;
  logic [7:0]      w_char;

  always_comb begin
    w_req8             = 8'h00;
    w_req8[NREQ-1:0]   = i_req;
  end

  assign w_win      = rr_winner(w_req8, r_ptr, NREQ);
  assign w_win_byte = i_req_data[8*int'(w_win) +: 8];
  assign w_win_inc  = (32'(w_win) == NREQ - 1) ? 3'd0 : w_win + 3'd1;

  // Single converter: grant byte's high nibble in IDLE, held low nibble after.
  assign w_nib = (r_state == IDLE) ? w_win_byte[7:4] : r_lo_nib;

  hex_nibble_to_ascii #(
    .UPPER (UPPER)
  ) u_nib (
    .i_nib  (w_nib),
    .o_char (w_char)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_lo_nib_nxt = r_lo_nib;
    w_ack_nxt    = '0;
    w_valid_nxt  = r_tx_valid;
    w_byte_nxt   = r_tx_byte;
    case (r_state)
      IDLE: begin
        if (|i_req) begin
          w_state_nxt  = HI;
          w_lo_nib_nxt = w_win_byte[3:0];
          w_ack_nxt    = NREQ'(1) << w_win;
          w_valid_nxt  = 1'b1;
          w_byte_nxt   = w_char;
          w_ptr_nxt    = w_win_inc;
        end
      end
      HI: begin
        if (i_tx_ready) begin
          w_state_nxt = LO;
          w_byte_nxt  = w_char;
        end
      end
      LO: begin
        if (i_tx_ready) begin
`ifdef HEX_PRINT_SEPARATOR_EN
          w_state_nxt = SEP;
          w_byte_nxt  = ASCII_SPACE;
`else
          w_state_nxt = IDLE;
          w_valid_nxt = 1'b0;
`endif
        end
      end
      default: begin
`ifdef HEX_PRINT_SEPARATOR_EN
        if (i_tx_ready) begin
          w_state_nxt = IDLE;
          w_valid_nxt = 1'b0;
        end
`else
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= 3'd0;
      r_lo_nib   <= 4'h0;
      r_ack      <= '0;
      r_tx_valid <= 1'b0;
      r_tx_byte  <= 8'h00;
    end else begin
      r_ptr      <= w_ptr_nxt;
      r_lo_nib   <= w_lo_nib_nxt;
      r_ack      <= w_ack_nxt;
      r_tx_valid <= w_valid_nxt;
      r_tx_byte  <= w_byte_nxt;
    end
  end

  assign o_ack      = r_ack;
  assign o_tx_valid = r_tx_valid;
  assign o_tx_byte  = r_tx_byte;
  assign o_busy     = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_hex_print_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_hex_print_arbiter
// Purpose: Directed self-checking bench for hex_print_arbiter (NREQ=4), with a
//          second instance built for lower-case hex digits.
// Config : HEX_PRINT_SEPARATOR_EN - expects the trailing space character.
// Revision: 1.0  initial release
// ============================================================================
module tb_hex_print_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  r_req, r_req_l;
  logic [31:0] r_data, r_data_l;
  logic        r_ready, r_ready_l;

  logic [3:0]  w_ack, w_ack_l;
  logic        w_valid, w_valid_l;
  logic [7:0]  w_byte, w_byte_l;
  logic        w_busy, w_busy_l;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hex_print_arbiter #(.NREQ(4), .UPPER(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (r_req),
    .i_req_data (r_data),
    .o_ack      (w_ack),
    .o_tx_valid (w_valid),
    .i_tx_ready (r_ready),
    .o_tx_byte  (w_byte),
    .o_busy     (w_busy)
  );

  hex_print_arbiter #(.NREQ(4), .UPPER(1'b0)) dut_l (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (r_req_l),
    .i_req_data (r_data_l),
    .o_ack      (w_ack_l),
    .o_tx_valid (w_valid_l),
    .i_tx_ready (r_ready_l),
    .o_tx_byte  (w_byte_l),
    .o_busy     (w_busy_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    r_req   = 4'b0000;
    r_req_l = 4'b0000;
    r_ready   = 1'b1;
    r_ready_l = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Called in the cycle after a grant edge (HI state) with ready held high.
  task automatic expect_stream(input string tag, input logic [7:0] c0, input logic [7:0] c1);
    check({tag, "_v0"}, 32'(w_valid), 32'd1);
    check({tag, "_c0"}, 32'(w_byte), 32'(c0));
    tick();
    check({tag, "_c1"}, 32'(w_byte), 32'(c1));
    check({tag, "_ack0"}, 32'(w_ack), 32'd0);
    tick();
`ifdef HEX_PRINT_SEPARATOR_EN
    check({tag, "_sp"}, 32'(w_byte), 32'h20);
    check({tag, "_vsp"}, 32'(w_valid), 32'd1);
    tick();
`endif
    check({tag, "_vend"}, 32'(w_valid), 32'd0);
    check({tag, "_busyend"}, 32'(w_busy), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    r_req     = 4'b0000;
    r_req_l   = 4'b0000;
    r_data    = 32'h0;
    r_data_l  = 32'h0;
    r_ready   = 1'b1;
    r_ready_l = 1'b1;
    #2;
    check("rst_valid", 32'(w_valid), 32'd0);
    check("rst_byte",  32'(w_byte),  32'h00);
    check("rst_busy",  32'(w_busy),  32'd0);
    check("rst_ack",   32'(w_ack),   32'd0);

    // 1: single requester 0, byte A7
    do_reset();
    r_req = 4'b0001;
    r_data = 32'h0000_00A7;
    tick();
    check("t1_ack", 32'(w_ack), 32'b0001);
    check("t1_busy", 32'(w_busy), 32'd1);
    r_req = 4'b0000;
    expect_stream("t1", 8'h41, 8'h37);

    // 2: all four requesting, round-robin 0,1,2,3,0
    do_reset();
    r_data = 32'h3322_1100;
    r_req  = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      check($sformatf("t2_ack%0d", g), 32'(w_ack), 32'(4'b0001 << (g % 4)));
      expect_stream($sformatf("t2_s%0d", g), 8'h30 + 8'(g % 4), 8'h30 + 8'(g % 4));
    end
    r_req = 4'b0000;

    // 3: backpressure holds the first character stable
    do_reset();
    r_req   = 4'b0001;
    r_data  = 32'h0000_003C;
    r_ready = 1'b0;
    tick();
    r_req = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("t3_hold_b%0d", k), 32'(w_byte), 32'h33);
      check($sformatf("t3_hold_v%0d", k), 32'(w_valid), 32'd1);
    end
    r_ready = 1'b1;
    expect_stream("t3", 8'h33, 8'h43);

    // 5: async reset while in LO truncates the stream
    do_reset();
    r_req  = 4'b0001;
    r_data = 32'h0000_0055;
    tick();
    r_req = 4'b0000;
    tick();
    check("t5_lo_byte", 32'(w_byte), 32'h35);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(w_valid), 32'd0);
    check("t5_rst_ack",   32'(w_ack),   32'd0);
    check("t5_rst_busy",  32'(w_busy),  32'd0);
    rst_n  = 1'b1;
    r_req  = 4'b0010;
    r_data = 32'h0000_9B00;
    tick();
    check("t5_ack", 32'(w_ack), 32'b0010);
    r_req = 4'b0000;
    expect_stream("t5", 8'h39, 8'h42);

    // 6: pointer moves past the winner and wraps; late data change ignored
    do_reset();
    r_req  = 4'b0100;
    r_data = 32'h4F2D_0001;
    tick();
    check("t6_ack2", 32'(w_ack), 32'b0100);
    r_req  = 4'b1101;
    r_data = 32'h4FFF_0001;
    expect_stream("t6_s2", 8'h32, 8'h44);
    tick();
    check("t6_ack3", 32'(w_ack), 32'b1000);
    r_req = 4'b0001;
    expect_stream("t6_s3", 8'h34, 8'h46);
    tick();
    check("t6_ack0", 32'(w_ack), 32'b0001);
    r_req = 4'b0000;
    expect_stream("t6_s0", 8'h30, 8'h31);

    // 4: lower-case instance, byte FE
    do_reset();
    r_req_l  = 4'b0001;
    r_data_l = 32'h0000_00FE;
    tick();
    check("t4_ack", 32'(w_ack_l), 32'b0001);
    check("t4_c0", 32'(w_byte_l), 32'h66);
    r_req_l = 4'b0000;
    tick();
    check("t4_c1", 32'(w_byte_l), 32'h65);
    tick();
`ifdef HEX_PRINT_SEPARATOR_EN
    check("t4_sp", 32'(w_byte_l), 32'h20);
    tick();
`endif
    check("t4_vend", 32'(w_valid_l), 32'd0);
    check("t4_busyend", 32'(w_busy_l), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
